mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 2:1 data mux between two requesters (A, B).
//  Drives the mux select, grants one side at a time, and forwards the selected
//  data downstream over a valid/ready handshake. A burst limit bounds how long
//  one side may hold the mux while the other waits.
// PARAMETERS
//  WIDTH      8   data width of a, b, y
//  MAX_BURST  4   max consecutive transfers per grant while the other side requests (>=1)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous reset, active low
//  req_a       in   1      A has valid data on a; held with a stable until ack_a
//  a           in   WIDTH  A data
//  ack_a       out  1      A beat accepted this cycle
//  req_b       in   1      B has valid data on b; held with b stable until ack_b
//  b           in   WIDTH  B data
//  ack_b       out  1      B beat accepted this cycle
//  s           out  1      mux select: 0 = A, 1 = B
//  gnt_a       out  1      A currently owns the mux
//  gnt_b       out  1      B currently owns the mux
//  y           out  WIDTH  muxed data (a when s=0, b when s=1)
//  y_valid     out  1      y holds a valid beat
//  y_ready     in   1      downstream accepts y this cycle
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, s=0, gnt_a=gnt_b=0, prio=0 (A first),
//    burst_cnt=0; y_valid, ack_a, ack_b = 0. y = a (s=0).
//  - States: IDLE, GNT_A, GNT_B. s, gnt_*, state, prio, burst_cnt are registered.
//  - IDLE: y_valid=0, no acks; s holds last value. Next state: both req -> side
//    given by prio; one req -> that side; none -> IDLE. Grant latency 1 cycle.
//  - GNT_x: s fixed to x; y_valid=req_x; ack_x=req_x & y_ready (combinational);
//    ack of other side = 0. Transfer = req_x & y_ready; on transfer burst_cnt++.
//  - Leaving GNT_x, evaluated each cycle:
//    * req_x=0: other req -> GNT_other directly (no IDLE bubble); else IDLE.
//    * transfer with burst_cnt==MAX_BURST-1: other req -> GNT_other; else stay,
//      burst_cnt wraps to 0.
//    * otherwise stay (y_ready=0 holds grant, burst_cnt unchanged, y stable).
//  - On entering GNT_x: burst_cnt<=0, prio<=other side (round robin).
//  - MAX_BURST=1: strict alternation per beat while both request.
//  - burst_cnt width max(1,$clog2(MAX_BURST)); never exceeds MAX_BURST-1.
//  - Reset mid-burst: in-flight beat dropped, requester must re-present it.
//  - No checking of requester protocol; dropping req before ack is legal and
//    treated as withdrawal.
// CONFIGURATION
//  MUX_ARB_STATS_EN defined: adds ports xfer_cnt_a, xfer_cnt_b (out, 16 each),
//    counting transfers per side; reset 0; wrap 16'hFFFF -> 0; increment in the
//    same cycle as the ack.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package mux_arb_pkg: state enum arb_state_t {IDLE, GNT_A, GNT_B}, SEL_A=1'b0,
//    SEL_B=1'b1 constants.
//  - Sub-module mux_arb_fsm: state, prio, burst_cnt, s/gnt registers.
//  - Top: mux_arb_fsm plus WIDTH instances of mux_2to1 (generate) for y,
//    ack/valid gating, optional stats counters.
// TESTING
//  1. Reset: rst_n=0 mid-activity -> immediately s=0, gnt_a=gnt_b=0, y_valid=0, acks 0.
//  2. Solo A: req_a=1, a=8'h5A, y_ready=1 from IDLE -> next cycle gnt_a=1, s=0,
//     y=8'h5A, y_valid=1, ack_a=1.
//  3. Contention, MAX_BURST=4, both req, y_ready=1 -> 4 A beats, 4 B beats,
//     4 A beats, no idle cycle between grants.
//  4. Backpressure: in GNT_B, y_ready=0 for 3 cycles -> ack_b=0, s=1 held,
//     y=b stable, burst_cnt unchanged; resumes count on y_ready=1.
//  5. Withdrawal: in GNT_A, req_a drops while req_b=1 -> next cycle gnt_b=1, s=1;
//     both drop -> IDLE, y_valid=0.
//  6. MUX_ARB_STATS_EN: 5 A beats, 3 B beats -> xfer_cnt_a=5, xfer_cnt_b=3;
//     preload to 16'hFFFF then one beat -> 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types for the round-robin 2:1 mux arbiter.
// Optional transfer statistics are enabled by defining MUX_ARB_STATS_EN.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2to1.sv
// One-bit 2:1 mux slice; the top replicates it across the data width.
module mux_2to1 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_arb_fsm.sv
// Grant FSM: owner state, round-robin priority, burst counter and registered select/grants.
module mux_arb_fsm
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic y_ready,
    output logic s,
    output logic gnt_a,
    output logic gnt_b
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    arb_state_t      state_q, state_d, other_st;
    logic            prio_q, prio_d;
    logic [CW-1:0]   burst_q, burst_d;
    logic            s_q, s_d;
    logic            gnt_a_q, gnt_b_q;
    logic            req_own, req_oth, xfer;

    always_comb begin
        req_own  = 1'b0;
        req_oth  = 1'b0;
        other_st = GNT_A;
        if (state_q == GNT_A) begin
            req_own  = req_a;
            req_oth  = req_b;
            other_st = GNT_B;
        end else if (state_q == GNT_B) begin
            req_own  = req_b;
            req_oth  = req_a;
            other_st = GNT_A;
        end
        xfer = req_own & y_ready;

        state_d = state_q;
        prio_d  = prio_q;
        burst_d = burst_q;
        s_d     = s_q;

        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) state_d = prio_q ? GNT_B : GNT_A;
                else if (req_a)     state_d = GNT_A;
                else if (req_b)     state_d = GNT_B;
            end
            GNT_A, GNT_B: begin
                // Withdrawal hands over straight to a waiting side, no idle bubble.
                if (!req_own) begin
                    state_d = req_oth ? other_st : IDLE;
                end else if (xfer) begin
                    if (burst_q == LAST) begin
                        burst_d = '0;
                        if (req_oth) state_d = other_st;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh grant restarts the burst and hands priority to the other side.
        if (state_d != state_q && state_d != IDLE) begin
            burst_d = '0;
            prio_d  = (state_d == GNT_A);
        end
        if (state_d == GNT_A) s_d = SEL_A;
        if (state_d == GNT_B) s_d = SEL_B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            burst_q <= '0;
            s_q     <= SEL_A;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            burst_q <= burst_d;
            s_q     <= s_d;
            gnt_a_q <= (state_d == GNT_A);
            gnt_b_q <= (state_d == GNT_B);
        end
    end

    assign s     = s_q;
    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter driving a shared 2:1 data mux onto a valid/ready output.
// Define MUX_ARB_STATS_EN to add per-side 16-bit transfer counters.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b,
    output logic             ack_b,
    output logic             s,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]      xfer_cnt_a,
    output logic [15:0]      xfer_cnt_b
`endif
);

    mux_arb_fsm #(.MAX_BURST(MAX_BURST)) u_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .y_ready (y_ready),
        .s       (s),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux_2to1 u_mux (
            .d0  (a[i]),
            .d1  (b[i]),
            .sel (s),
            .y   (y[i])
        );
    end

    assign y_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign ack_a   = gnt_a & req_a & y_ready;
    assign ack_b   = gnt_b & req_b & y_ready;

`ifdef MUX_ARB_STATS_EN
    logic [15:0] cnt_a_q, cnt_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (ack_a) cnt_a_q <= cnt_a_q + 16'd1;
            if (ack_b) cnt_b_q <= cnt_b_q + 16'd1;
        end
    end

    assign xfer_cnt_a = cnt_a_q;
    assign xfer_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomized bench for mux2_rr_arbiter against an owner/beat-count reference model.
// Stats checks are compiled in when MUX_ARB_STATS_EN is defined.
module tb_mux2_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_a = 1'b0, req_b = 1'b0, y_ready = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             ack_a, ack_b, s, gnt_a, gnt_b, y_valid;
    logic [WIDTH-1:0] y;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]      xfer_cnt_a, xfer_cnt_b;
`endif

    mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .a(a), .ack_a(ack_a),
        .req_b(req_b), .b(b), .ack_b(ack_b),
        .s(s), .gnt_a(gnt_a), .gnt_b(gnt_b),
        .y(y), .y_valid(y_valid), .y_ready(y_ready)
`ifdef MUX_ARB_STATS_EN
        , .xfer_cnt_a(xfer_cnt_a), .xfer_cnt_b(xfer_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner 0=none 1=A 2=B; beats = transfers done in current grant.
    int   m_own, m_prio, m_beats, m_cnt_a, m_cnt_b;
    logic m_s, e_ack_a, e_ack_b;
    logic smp_gnt_a, smp_gnt_b, smp_s, smp_vld, smp_ack_a, smp_ack_b;
    logic [WIDTH-1:0] smp_y;
    logic [15:0] smp_cnt_a, smp_cnt_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset;
        m_own = 0; m_prio = 0; m_beats = 0; m_s = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #1;
        chk("rst_s", s, 0);
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_ack_a", ack_a, 0);
        chk("rst_ack_b", ack_b, 0);
        chk("rst_y", y, a);
`ifdef MUX_ARB_STATS_EN
        chk("rst_cnt_a", xfer_cnt_a, 0);
        chk("rst_cnt_b", xfer_cnt_b, 0);
`endif
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic cyc(input logic ra, input logic [WIDTH-1:0] da,
                       input logic rb, input logic [WIDTH-1:0] db, input logic ry);
        logic rq_own, rq_oth;
        int   nxt;
        req_a = ra; a = da; req_b = rb; b = db; y_ready = ry;
        @(negedge clk);
        rq_own  = (m_own == 1) ? ra : (m_own == 2) ? rb : 1'b0;
        rq_oth  = (m_own == 1) ? rb : ra;
        e_ack_a = (m_own == 1) && ra && ry;
        e_ack_b = (m_own == 2) && rb && ry;
        chk("gnt_a", gnt_a, m_own == 1);
        chk("gnt_b", gnt_b, m_own == 2);
        chk("s", s, m_s);
        chk("y", y, m_s ? db : da);
        chk("y_valid", y_valid, rq_own);
        chk("ack_a", ack_a, e_ack_a);
        chk("ack_b", ack_b, e_ack_b);
        smp_gnt_a = gnt_a; smp_gnt_b = gnt_b; smp_s = s; smp_vld = y_valid;
        smp_ack_a = ack_a; smp_ack_b = ack_b; smp_y = y;
        smp_cnt_a = '0; smp_cnt_b = '0;
`ifdef MUX_ARB_STATS_EN
        chk("cnt_a", xfer_cnt_a, m_cnt_a);
        chk("cnt_b", xfer_cnt_b, m_cnt_b);
        smp_cnt_a = xfer_cnt_a; smp_cnt_b = xfer_cnt_b;
`endif
        if (e_ack_a) m_cnt_a = (m_cnt_a + 1) % 65536;
        if (e_ack_b) m_cnt_b = (m_cnt_b + 1) % 65536;
        nxt = m_own;
        if (m_own == 0) begin
            if (ra && rb) nxt = (m_prio == 0) ? 1 : 2;
            else if (ra)  nxt = 1;
            else if (rb)  nxt = 2;
        end else if (!rq_own) begin
            nxt = rq_oth ? 3 - m_own : 0;
        end else if (ry) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_beats = 0;
                if (rq_oth) nxt = 3 - m_own;
            end
        end
        if (nxt != 0 && nxt != m_own) begin
            m_beats = 0;
            m_prio  = (nxt == 1) ? 1 : 0;
            m_s     = (nxt == 2);
        end
        m_own = nxt;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [11:0] seq_a, seq_b;
        logic pa, pb, ry;
        logic [WIDTH-1:0] da, db;
        model_reset();
        #3;
        do_reset();

        // Solo A from idle: one cycle grant latency.
        cyc(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        chk("solo_idle_vld", smp_vld, 0);
        cyc(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        chk("solo_gnt_a", smp_gnt_a, 1);
        chk("solo_y", smp_y, 8'h5A);
        chk("solo_ack_a", smp_ack_a, 1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Contention: 4 A, 4 B, 4 A with no idle gap.
        do_reset();
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
            seq_a[11-i] = smp_gnt_a;
            seq_b[11-i] = smp_gnt_b;
        end
        chk("burst_seq_a", seq_a, 12'b1111_0000_1111);
        chk("burst_seq_b", seq_b, 12'b0000_1111_0000);

        // Backpressure in GNT_B: stall must not advance the burst.
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
            chk("bp_s", smp_s, 1);
            chk("bp_ack_b", smp_ack_b, 0);
            chk("bp_y", smp_y, 8'h22);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        chk("bp_still_b", smp_gnt_b, 1);
        cyc(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        chk("bp_resume_a", smp_gnt_a, 1);

        // Withdrawal: A drops with B waiting, then both drop.
        cyc(1'b0, 8'h11, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 8'h11, 1'b1, 8'h22, 1'b0);
        chk("wd_gnt_b", smp_gnt_b, 1);
        chk("wd_s", smp_s, 1);
        cyc(1'b0, 8'h11, 1'b0, 8'h22, 1'b1);
        cyc(1'b0, 8'h11, 1'b0, 8'h22, 1'b1);
        chk("wd_idle_gnt", {smp_gnt_a, smp_gnt_b}, 0);
        chk("wd_idle_vld", smp_vld, 0);

`ifdef MUX_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'h33, 1'b0, 8'h44, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h33, 1'b1, 8'h44, 1'b1);
        cyc(1'b0, 8'h33, 1'b0, 8'h44, 1'b1);
        chk("stats_a5", smp_cnt_a, 16'd5);
        chk("stats_b3", smp_cnt_b, 16'd3);
        do_reset();
        cyc(1'b1, 8'h33, 1'b0, 8'h44, 1'b1);
        for (int i = 0; i < 65535; i++) cyc(1'b1, 8'h33, 1'b0, 8'h44, 1'b1);
        cyc(1'b1, 8'h33, 1'b0, 8'h44, 1'b1);
        chk("stats_full", smp_cnt_a, 16'hFFFF);
        cyc(1'b1, 8'h33, 1'b0, 8'h44, 1'b1);
        chk("stats_wrap", smp_cnt_a, 16'h0000);
`endif

        // Randomized traffic with occasional withdrawal and a mid-run reset.
        do_reset();
        pa = 1'b0; pb = 1'b0; da = '0; db = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pa) begin
                pa = (i < 1000) ? 1'b1 : (($urandom % 3) != 0);
                da = WIDTH'($urandom);
            end else if (($urandom % 16) == 0) begin
                pa = 1'b0;
            end
            if (!pb) begin
                pb = (i < 1000) ? 1'b1 : (($urandom % 3) != 0);
                db = WIDTH'($urandom);
            end else if (($urandom % 16) == 0) begin
                pb = 1'b0;
            end
            ry = ($urandom % 4) != 0;
            cyc(pa, da, pb, db, ry);
            if (e_ack_a) pa = 1'b0;
            if (e_ack_b) pb = 1'b0;
            if (i == 1500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
